// File: rtl/dmux_pkg.sv
// Shared constants and types for the 4-way demux router.
// Lane indices, FIFO depth and the push-decode helper.
package dmux_pkg;

  localparam int NUM_LANES  = 4;
  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0] lane_t;
  typedef logic [1:0] cnt_t;

  localparam lane_t LANE_A = 2'd0;
  localparam lane_t LANE_B = 2'd1;
  localparam lane_t LANE_C = 2'd2;
  localparam lane_t LANE_D = 2'd3;

  function automatic logic [3:0] lane_onehot(
    input lane_t l
  );
    return 4'b0001 << l;
  endfunction

endpackage

// File: rtl/dmux4way_router_if.sv
// Upstream beat and four downstream lane handshakes.
// master drives beats and lane readies; slave is the router.
interface dmux4way_router_if #(
  parameter int W = 1
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         mode;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [1:0]   rr_ptr;

  modport master (
    output in_valid,
    output in_data,
    output in_sel,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  a,
    input  b,
    input  c,
    input  d,
    input  rr_ptr
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sel,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output a,
    output b,
    output c,
    output d,
    output rr_ptr
  );

endinterface

// File: rtl/lane_fifo2.sv
// Two-entry FIFO for one router lane.
// Head register doubles as the lane output and holds when empty.
module lane_fifo2
  import dmux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic         full,
  output logic [W-1:0] dout
);

  cnt_t         cnt_q;
  cnt_t         cnt_d;
  logic [W-1:0] head_q;
  logic [W-1:0] head_d;
  logic [W-1:0] tail_q;
  logic [W-1:0] tail_d;
  logic         do_push;
  logic         do_pop;

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == cnt_t'(FIFO_DEPTH));
  assign dout    = head_q;
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (1'b1)
      // Push and pop together only happen at count 1.
      (do_push && do_pop): begin
        head_d = din;
      end
      (do_push && !do_pop): begin
        if (cnt_q == '0) head_d = din;
        else             tail_d = din;
        cnt_d = cnt_q + cnt_t'(1);
      end
      (!do_push && do_pop): begin
        if (full) head_d = tail_q;
        cnt_d = cnt_q - cnt_t'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/dmux4way_router.sv
// Routes upstream beats into four 2-deep lane FIFOs,
// by explicit select or by a round-robin pointer.
module dmux4way_router
  import dmux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmux4way_router_if.slave     bus
);

  lane_t        target;
  lane_t        rr_ptr_q;
  lane_t        rr_ptr_d;
  logic         accept;
  logic [3:0]   push_en;
  logic [3:0]   pop_en;
  logic [3:0]   lane_valid;
  logic [3:0]   lane_full;
  logic [W-1:0] lane_head [NUM_LANES];

  always_comb begin
    target = bus.in_sel;
    unique case (1'b1)
      bus.mode:  target = rr_ptr_q;
      !bus.mode: target = bus.in_sel;
      default:   ;
    endcase
  end

  assign bus.in_ready = !lane_full[target];
  assign accept       = bus.in_valid && bus.in_ready;
  assign push_en      = accept ? lane_onehot(target) : 4'b0000;
  assign pop_en       = lane_valid & bus.out_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (bus.mode && accept) rr_ptr_d = rr_ptr_q + lane_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= LANE_A;
    else        rr_ptr_q <= rr_ptr_d;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo2 #(
      .W (W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_en[i]),
      .pop   (pop_en[i]),
      .din   (bus.in_data),
      .valid (lane_valid[i]),
      .full  (lane_full[i]),
      .dout  (lane_head[i])
    );
  end

  assign bus.out_valid = lane_valid;
  assign bus.rr_ptr    = rr_ptr_q;
  assign bus.a         = lane_head[LANE_A];
  assign bus.b         = lane_head[LANE_B];
  assign bus.c         = lane_head[LANE_C];
  assign bus.d         = lane_head[LANE_D];

endmodule

// File: tb/tb_dmux4way_router.sv
// Directed plus random bench for dmux4way_router.
// Per-lane queues act as the scoreboard for heads and ordering.
module tb_dmux4way_router;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  dmux4way_router_if #(.W(W)) bus ();

  dmux4way_router #(
    .W (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q [4][$];
  logic [W-1:0] last_head [4];
  logic [1:0]   exp_rr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_out(input int i);
    case (i)
      0:       return bus.a;
      1:       return bus.b;
      2:       return bus.c;
      default: return bus.d;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      last_head[i] = '0;
    end
    exp_rr = 2'd0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, ":a"}, 32'(bus.a), 32'h0);
    chk({tag, ":b"}, 32'(bus.b), 32'h0);
    chk({tag, ":c"}, 32'(bus.c), 32'h0);
    chk({tag, ":d"}, 32'(bus.d), 32'h0);
    chk({tag, ":rr_ptr"}, 32'(bus.rr_ptr), 32'h0);
    chk({tag, ":in_ready"}, 32'(bus.in_ready), 32'h1);
  endtask

  // One clock cycle: drive, check at the falling edge, update model.
  task automatic step(input string tag, input bit v, input logic [1:0] sel,
                      input logic [W-1:0] dat, input bit md,
                      input logic [3:0] ordy);
    logic [1:0] tgt;
    bit         acc;
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = dat;
    bus.mode      = md;
    bus.out_ready = ordy;
    #4;
    tgt = md ? exp_rr : sel;
    acc = v && (q[tgt].size() < 2);
    chk({tag, ":rr_ptr"}, 32'(bus.rr_ptr), 32'(exp_rr));
    chk({tag, ":in_ready"}, 32'(bus.in_ready), 32'(q[tgt].size() < 2));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s:out_valid%0d", tag, i),
          32'(bus.out_valid[i]), 32'(q[i].size() != 0));
      if (q[i].size() != 0) last_head[i] = q[i][0];
      chk($sformatf("%s:lane%0d", tag, i),
          32'(lane_out(i)), 32'(last_head[i]));
    end
    for (int i = 0; i < 4; i++)
      if (q[i].size() != 0 && ordy[i]) void'(q[i].pop_front());
    if (acc) begin
      q[tgt].push_back(dat);
      if (md) exp_rr = exp_rr + 2'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = 2'd0;
    bus.mode      = 1'b0;
    bus.out_ready = 4'b0000;
    model_clear();
    #2;
    check_reset("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single beat to lane c
    step("c_push", 1, 2'd2, 4'd1, 0, 4'b0000);
    chk("c_only_valid", 32'(bus.out_valid), 32'h4);
    chk("c_data", 32'(bus.c), 32'h1);
    step("c_pop", 0, 2'd0, 4'd0, 0, 4'b0100);

    // Lane a fills to 2 and back-pressures
    step("a_fill0", 1, 2'd0, 4'd5, 0, 4'b0000);
    step("a_fill1", 1, 2'd0, 4'd6, 0, 4'b0000);
    step("a_block", 1, 2'd0, 4'd7, 0, 4'b0000);
    chk("a_full_ready", 32'(bus.in_ready), 32'h0);
    chk("a_full_valid", 32'(bus.out_valid), 32'h1);

    // Stalled lane a does not block lane d
    step("d_bypass", 1, 2'd3, 4'd9, 0, 4'b0000);
    chk("d_valid", 32'(bus.out_valid[3]), 32'h1);
    step("drain0", 0, 2'd0, 4'd0, 0, 4'b1001);
    step("drain1", 0, 2'd0, 4'd0, 0, 4'b0001);
    step("drain2", 0, 2'd0, 4'd0, 0, 4'b0000);

    // Round-robin eight beats
    for (int i = 0; i < 8; i++)
      step($sformatf("rr%0d", i), 1, 2'd0, 4'(i % 2), 1, 4'b1111);
    step("rr_end", 0, 2'd0, 4'd0, 1, 4'b1111);
    chk("rr_wrap", 32'(bus.rr_ptr), 32'h0);

    // Lane b simultaneous push and pop at count 1
    step("b_push", 1, 2'd1, 4'd3, 0, 4'b0000);
    step("b_pushpop", 1, 2'd1, 4'hA, 0, 4'b0010);
    step("b_check", 0, 2'd0, 4'd0, 0, 4'b0000);
    chk("b_new_head", 32'(bus.b), 32'hA);
    step("b_drain", 0, 2'd0, 4'd0, 0, 4'b0010);

    // Mode switching keeps the pointer
    step("ms0", 1, 2'd0, 4'd2, 1, 4'b1111);
    step("ms1", 1, 2'd3, 4'd4, 0, 4'b1111);
    step("ms2", 1, 2'd0, 4'd8, 1, 4'b1111);
    step("ms3", 0, 2'd0, 4'd0, 0, 4'b1111);

    // Random traffic
    for (int i = 0; i < 80; i++)
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // Asynchronous reset with data held
    step("pre0", 1, 2'd0, 4'hB, 1, 4'b0000);
    step("pre1", 1, 2'd0, 4'hC, 1, 4'b0000);
    step("pre2", 1, 2'd0, 4'hD, 0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post0", 1, 2'd1, 4'hE, 0, 4'b0000);
    step("post1", 0, 2'd0, 4'd0, 0, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
